// File: rtl/timer_counter_pkg.sv
// Shared definitions for the TC0/TC1 timer/counter peripherals and the bridge decode.
package timer_counter_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped count-down timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload, masked IRQ.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] CTRL_MASK = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    tc_state_e   state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        wr_ctrl, wr_preset;
    logic        flag_set, flag_fsm_clr, en_fsm_clr;
    logic [1:0]  mode;
    logic        unused_addr;

    assign unused_addr = ^addr[29:2];
    assign wr_ctrl     = we && (addr[1:0] == REG_CTRL);
    assign wr_preset   = we && (addr[1:0] == REG_PRESET);
    assign mode        = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        preset_d     = preset_q;
        count_d      = count_q;
        flag_set     = 1'b0;
        flag_fsm_clr = 1'b0;
        en_fsm_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = '0;
                    flag_set = 1'b1;
                    state_d  = ST_INT;
                end
            end
            ST_INT: begin
                // Modes 10/11 behave as one-shot.
                if (mode == MODE_RELOAD) flag_fsm_clr = 1'b1;
                else                     en_fsm_clr   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU CTRL write overrides the FSM's EN clear; FSM flag set overrides CPU clear.
        if (en_fsm_clr) ctrl_d[CTRL_EN] = 1'b0;
        if (wr_ctrl)    ctrl_d = din & CTRL_MASK;
        if (wr_preset)  preset_d = din;
        flag_d = flag_set | (flag_q & ~(wr_ctrl | wr_preset | flag_fsm_clr));
    end

    always_comb begin
        case (addr[1:0])
            REG_CTRL:   dout = ctrl_q;
            REG_PRESET: dout = preset_q;
            REG_COUNT:  dout = count_q;
            default:    dout = '0;
        endcase
    end

    assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed scenarios plus random register traffic
// checked against an edge-indexed model of load/expiry times.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    timer_counter #(.CTRL_MASK(32'h0000_000F)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ra;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: timing derived from the edge the timer leaves idle (start), the load edge
    // (start+1) and the expiry edge (load + max(PRESET,1)).
    logic [31:0] m_ctrl, m_preset, m_count, m_load;
    logic        m_flag;
    bit          m_active;
    longint      m_edge, m_start, m_fire;

    function automatic void model_reset();
        m_ctrl = '0; m_preset = '0; m_count = '0; m_load = '0;
        m_flag = 1'b0; m_active = 0; m_start = 0; m_fire = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] ra);
        case (ra)
            2'd0:    return m_ctrl;
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input bit w, input logic [1:0] wa, input logic [31:0] d);
        bit set_f = 0, clr_f = 0, drop_en = 0;
        longint e;
        m_edge++;
        e = m_edge;
        if (!m_active) begin
            if (m_ctrl[0]) begin m_active = 1; m_start = e; end
        end else if (e == m_start + 1) begin
            m_load  = m_preset;
            m_count = m_preset;
            m_fire  = e + ((m_preset > 32'd1) ? longint'(m_preset) : 1);
        end else if (e <= m_fire) begin
            if (!m_ctrl[0]) m_active = 0;
            else if (e == m_fire) begin m_count = '0; set_f = 1; end
            else m_count = 32'(longint'(m_load) - (e - m_start - 1));
        end else begin
            if (m_ctrl[2:1] == 2'b01) clr_f = 1;
            else drop_en = 1;
            m_active = 0;
        end
        if (w && wa == 2'd0) begin m_ctrl = d & 32'hF; clr_f = 1; end
        else if (drop_en) m_ctrl[0] = 1'b0;
        if (w && wa == 2'd1) begin m_preset = d; clr_f = 1; end
        if (set_f) m_flag = 1'b1;
        else if (clr_f) m_flag = 1'b0;
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check($sformatf("dout[off %0d]", x.ra), dout, x.dout);
                check("irq", {31'd0, irq}, {31'd0, x.irq});
            end
        end
    end

    task automatic push_exp(input logic [1:0] ra);
        exp_t x;
        x.ra   = ra;
        x.dout = m_read(ra);
        x.irq  = m_ctrl[3] & m_flag;
        sb.push_back(x);
    endtask

    task automatic step(input bit w, input logic [1:0] wa, input logic [31:0] d, input logic [1:0] ra);
        we   = w;
        addr = {28'($urandom), wa};
        din  = d;
        @(posedge clk); #1;
        model_edge(w, wa, d);
        we   = 1'b0;
        addr = {28'($urandom), ra};
        push_exp(ra);
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n, input logic [1:0] ra);
        for (int i = 0; i < n; i++) step(0, 2'd0, 32'd0, ra);
    endtask

    task automatic do_reset(input logic [1:0] ra);
        we    = 1'b0;
        addr  = {28'($urandom), ra};
        reset = 1'b1;
        model_reset();
        #1;
        check("async rst dout", dout, m_read(ra));
        check("async rst irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        push_exp(ra);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  wa;
        logic [31:0] d;
        int          guard;
        reset = 1'b1; we = 1'b0; addr = '0; din = '0; m_edge = 0;
        model_reset();
        @(negedge clk); #1;
        do_reset(2'd0);
        idle(2, 2'd2);

        // One-shot, PRESET=5: COUNT walk, sticky irq, EN auto-clear, PRESET write drops irq.
        step(1, 2'd1, 32'd5, 2'd1);
        step(1, 2'd0, 32'h9, 2'd2);
        idle(9, 2'd2);
        idle(2, 2'd0);
        step(1, 2'd1, 32'd5, 2'd0);
        idle(2, 2'd2);

        // Auto-reload, PRESET=3: three one-cycle pulses.
        step(1, 2'd1, 32'd3, 2'd1);
        step(1, 2'd0, 32'hB, 2'd2);
        idle(20, 2'd0);

        // IM=0: flag set silently, then CTRL write clears it.
        step(1, 2'd1, 32'd2, 2'd0);
        step(1, 2'd0, 32'h1, 2'd2);
        idle(4, 2'd2);
        step(1, 2'd0, 32'h9, 2'd0);
        idle(8, 2'd0);

        // Disable mid-count freezes COUNT; re-enable reloads.
        step(1, 2'd1, 32'd10, 2'd2);
        step(1, 2'd0, 32'h9, 2'd2);
        guard = 0;
        while (m_count != 32'd6 && guard < 30) begin
            step(0, 2'd0, 32'd0, 2'd2);
            guard++;
        end
        check("reach COUNT=6", 32'(guard < 30), 32'd1);
        step(1, 2'd0, 32'h8, 2'd2);
        idle(4, 2'd2);
        step(1, 2'd0, 32'h9, 2'd2);
        idle(4, 2'd2);

        // Read-only / unused offsets and CTRL masking.
        step(1, 2'd2, 32'hFFFF_FFFF, 2'd2);
        step(1, 2'd3, 32'hFFFF_FFFF, 2'd3);
        step(1, 2'd0, 32'hFFFF_FFFF, 2'd0);
        idle(3, 2'd2);

        // Async reset mid-count.
        step(1, 2'd1, 32'd5, 2'd0);
        step(1, 2'd0, 32'h9, 2'd2);
        idle(4, 2'd2);
        do_reset(2'd0);
        idle(2, 2'd2);

        // Random register traffic.
        for (int i = 0; i < 500; i++) begin
            wa = 2'($urandom_range(0, 3));
            case (wa)
                2'd0:    d = $urandom | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                2'd1:    d = 32'($urandom_range(0, 7));
                default: d = $urandom;
            endcase
            step($urandom_range(0, 9) == 0, wa, d, 2'($urandom_range(0, 3)));
        end

        @(negedge clk); #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
